// File: rtl/sram_bridge_ctrl.sv
// Byte-stream to single-port SRAM bridge: CMD/ADDR/data frames from a UART receiver,
// single or burst word reads and writes, read data or an ack byte back to the transmitter.
module sram_bridge_ctrl #(
   parameter int         DATA_BYTES = 4,
   parameter int         ADDR_W     = 5,
   parameter int         RD_LAT     = 1,
   parameter logic [7:0] ACK_BYTE   = 8'hAC
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   output logic                      rx_ready,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      csb_n,
   output logic                      we_n,
   output logic [ADDR_W-1:0]         addr,
   output logic [8*DATA_BYTES-1:0]   sram_din,
   input  logic [8*DATA_BYTES-1:0]   sram_dout,
   output logic                      busy
);

   localparam int         W        = 8 * DATA_BYTES;
   localparam logic [2:0] DB_LAST  = 3'(DATA_BYTES - 1);
   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_RREQ, S_RWAIT, S_RSEND, S_ACK
   } state_t;

   state_t            state_reg;
   logic              is_read_reg;
   logic [6:0]        len_cnt_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [2:0]        byte_idx_reg;
   logic [1:0]        lat_cnt_reg;
   logic [W-1:0]      wbuf_reg;
   logic [W-1:0]      wbuf_next;
   logic [W-1:0]      tx_shift_reg;
   logic [W-1:0]      tx_shift_next;
   logic [7:0]        tx_data_reg;
   logic              tx_valid_reg;
   logic              rx_fire;
   logic              tx_fire;
   logic [DATA_BYTES-1:0] byte_wr;

   assign rx_fire       = rx_valid && rx_ready;
   assign tx_fire       = tx_valid_reg && tx_ready;
   assign tx_shift_next = tx_shift_reg >> 8;

   // Incoming bytes land LSB first in the lane selected by the byte index.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_BYTES; gi++) begin : g_wlane
         assign byte_wr[gi] = (state_reg == S_WDATA) && rx_valid && (byte_idx_reg == 3'(gi));
         assign wbuf_next[gi*8 +: 8] = byte_wr[gi] ? rx_data : wbuf_reg[gi*8 +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         is_read_reg  <= 1'b0;
         len_cnt_reg  <= '0;
         addr_reg     <= '0;
         byte_idx_reg <= '0;
         lat_cnt_reg  <= '0;
         wbuf_reg     <= '0;
         tx_shift_reg <= '0;
         tx_data_reg  <= '0;
         tx_valid_reg <= 1'b0;
      end else begin
         wbuf_reg <= wbuf_next;
         case (state_reg)
            S_IDLE: begin
               if (rx_fire) begin
                  is_read_reg <= rx_data[7];
                  len_cnt_reg <= rx_data[6:0];
                  state_reg   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (rx_fire) begin
                  addr_reg     <= rx_data[ADDR_W-1:0];
                  byte_idx_reg <= '0;
                  state_reg    <= is_read_reg ? S_RREQ : S_WDATA;
               end
            end
            S_WDATA: begin
               if (rx_fire) begin
                  if (byte_idx_reg == DB_LAST) begin
                     byte_idx_reg <= '0;
                     state_reg    <= S_WRITE;
                  end else begin
                     byte_idx_reg <= byte_idx_reg + 3'd1;
                  end
               end
            end
            S_WRITE: begin
               addr_reg <= addr_reg + 1'b1;
               if (len_cnt_reg == 7'd0) begin
                  tx_data_reg  <= ACK_BYTE;
                  tx_valid_reg <= 1'b1;
                  state_reg    <= S_ACK;
               end else begin
                  len_cnt_reg <= len_cnt_reg - 7'd1;
                  state_reg   <= S_WDATA;
               end
            end
            S_RREQ: begin
               addr_reg    <= addr_reg + 1'b1;
               lat_cnt_reg <= '0;
               state_reg   <= S_RWAIT;
            end
            S_RWAIT: begin
               // Capture on the edge ending the last wait cycle; the word is held from here on.
               if (lat_cnt_reg == LAT_LAST) begin
                  tx_shift_reg <= sram_dout;
                  tx_data_reg  <= sram_dout[7:0];
                  tx_valid_reg <= 1'b1;
                  byte_idx_reg <= '0;
                  state_reg    <= S_RSEND;
               end else begin
                  lat_cnt_reg <= lat_cnt_reg + 2'd1;
               end
            end
            S_RSEND: begin
               if (tx_fire) begin
                  if (byte_idx_reg == DB_LAST) begin
                     tx_valid_reg <= 1'b0;
                     byte_idx_reg <= '0;
                     if (len_cnt_reg == 7'd0) begin
                        state_reg <= S_IDLE;
                     end else begin
                        len_cnt_reg <= len_cnt_reg - 7'd1;
                        state_reg   <= S_RREQ;
                     end
                  end else begin
                     byte_idx_reg <= byte_idx_reg + 3'd1;
                     tx_shift_reg <= tx_shift_next;
                     tx_data_reg  <= tx_shift_next[7:0];
                  end
               end
            end
            S_ACK: begin
               if (tx_fire) begin
                  tx_valid_reg <= 1'b0;
                  state_reg    <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      rx_ready = (state_reg == S_IDLE) || (state_reg == S_ADDR) || (state_reg == S_WDATA);
      csb_n    = !((state_reg == S_WRITE) || (state_reg == S_RREQ));
      we_n     = (state_reg != S_WRITE);
      busy     = (state_reg != S_IDLE);
   end

   assign addr     = addr_reg;
   assign sram_din = wbuf_reg;
   assign tx_data  = tx_data_reg;
   assign tx_valid = tx_valid_reg;

endmodule

// File: doc/sram_bridge_ctrl.md
# sram_bridge_ctrl

Byte-stream-to-SRAM bridge: takes command, address and data bytes from the UART receiver and performs single-word or burst reads and writes on a single-port SRAM macro. It returns read data, or a write acknowledge byte, through the UART transmitter. Word width, address width and SRAM read latency are parameters. It sits between the UART rx/tx pair and the SRAM macro.

## Interface
- DATA_BYTES, 4, bytes per SRAM word (1..8); word width W = 8*DATA_BYTES
- ADDR_W, 5, SRAM address width (1..8)
- RD_LAT, 1, cycles from read-strobe cycle to valid sram_dout (1..4)
- ACK_BYTE, 8'hAC, byte sent after a completed write burst
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts byte; transfer when rx_valid && rx_ready
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held with tx_data stable until accepted
- tx_ready  in  1  transmitter accepts; transfer when tx_valid && tx_ready
- csb_n  out  1  SRAM chip select, active-low
- we_n  out  1  SRAM write enable, active-low (1 = read)
- addr  out  ADDR_W  SRAM address
- sram_din  out  W  SRAM write data
- sram_dout  in  W  SRAM read data
- busy  out  1  high whenever state != IDLE

## Operation
- Frame: CMD byte, ADDR byte, then data. CMD[7] = 1 read / 0 write; CMD[6:0] = LEN, burst of LEN+1 words (1..128). ADDR bits above ADDR_W are ignored.
- Word byte order is LSB first on both rx and tx.
- States:
  - IDLE: rx_ready=1. On accept, latch CMD -> ADDR.
  - ADDR: rx_ready=1. On accept, latch address; read -> RREQ, write -> WDATA.
  - WDATA: rx_ready=1. Shift in bytes; after DATA_BYTES accepted -> WRITE.
  - WRITE: one cycle, csb_n=0, we_n=0, addr=current address, sram_din=assembled word. Then -> WDATA if words remain, else -> ACK.
  - RREQ: one cycle, csb_n=0, we_n=1, addr=current address. Then -> RWAIT.
  - RWAIT: RD_LAT cycles. sram_dout is captured into the tx shift register at the edge ending the last RWAIT cycle. Then -> RSEND.
  - RSEND: sends DATA_BYTES bytes. Then -> RREQ if words remain, else -> IDLE.
  - ACK: sends ACK_BYTE, then -> IDLE.
- rx_ready=0 in WRITE, RREQ, RWAIT, RSEND and ACK. Bytes arriving then stay pending at the receiver.
- csb_n=1 and we_n=1 in every state other than WRITE/RREQ. No SRAM access otherwise.
- Address increments after each WRITE and each RREQ, modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
- Word counter loads LEN and decrements per word; the burst ends when it is 0 at the word boundary.
- The captured read word is held internally, so sram_dout may change after the capture.
- Reset (any time, including mid-burst): state IDLE, counters 0, partial word discarded. No SRAM access and no tx byte is issued for the aborted frame.
- Output reset values: csb_n=1, we_n=1, addr=0, sram_din=0, tx_valid=0, tx_data=0, busy=0, rx_ready=1 (IDLE decode).

## Timing
- rx_ready, csb_n, we_n and busy are Moore decodes of the registered state. tx_valid and tx_data are registered.
- Write: last data byte of a word accepted in cycle N -> WRITE in cycle N+1.
- Write burst end: WRITE of the last word in cycle M -> tx_valid=1 with ACK_BYTE from cycle M+1.
- Read: ADDR accepted in cycle N -> RREQ in N+1, RWAIT in N+2..N+1+RD_LAT, first tx_valid in N+2+RD_LAT.
- In RSEND, after each accepted byte, tx_valid stays high with the next byte on the following cycle. Max throughput is 1 byte/cycle when tx_ready is held high.
- tx_ready low stalls indefinitely; tx_data must not change while tx_valid && !tx_ready.
- Between words of a read burst, tx_valid drops for 1+RD_LAT cycles (RREQ + RWAIT).

## Test plan
- Write: single write, DATA_BYTES=4, ADDR_W=5. Send 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44 -> one WRITE cycle with addr=3, sram_din=32'h44332211, we_n=0; then tx byte 8'hAC; busy low afterwards.
- Read with stall: SRAM model holds 32'hDEADBEEF at addr 3. Send 8'h80, 8'h03 with tx_ready held low 5 cycles -> tx_valid high and tx_data=8'hEF stable through the stall; then EF, BE, AD, DE in order; first tx_valid exactly RD_LAT+2 cycles after the ADDR accept.
- Write burst wrap: 8'h02 (LEN=2), ADDR 8'h1F, 12 data bytes -> WRITEs at addr 31, 0, 1; a single ACK only after the third.
- RD_LAT=3 read burst: LEN=1 read at addr 0 -> RREQ cycles separated by 3 RWAIT cycles plus the 4 RSEND bytes; captured data correct even though the model drives garbage outside its valid cycle.
- Reset mid-frame: reset asserted after the 2nd of 4 write data bytes -> no WRITE, no ACK, all outputs at reset values. A following full write frame behaves as in the first scenario.
- Ignored address bits and backpressure: ADDR byte 8'hE5 with ADDR_W=5 -> addr=5. rx_valid held high during WRITE/ACK -> rx_ready=0 there and no byte is lost or double-counted.
